branch_predictor: RTL and testbench

//  IF-stage dynamic branch predictor: 2-bit saturating-counter BHT plus direct-mapped BTB.

---
 rtl/branch_predictor_if.sv | 38 +++
 rtl/branch_predictor.sv | 115 +++++++++++
 tb/tb_branch_predictor.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Fetch lookup and EX-resolution bundle for the branch predictor.
// Latency: lookup outputs and mispredict flag are combinational; training lands on the next edge.
// Backpressure: none; every feedback cycle is absorbed, no ready signal.
interface branch_predictor_if #(
    parameter int BHT_IW = 6
);
    // IF-stage lookup
    logic [31:0]       IF_pc;
    logic              pred_taken;
    logic [31:0]       pred_target;
    logic [BHT_IW-1:0] pred_bht_idx;

    // EX-stage resolution
    logic              EX_feedback_valid;
    logic [31:0]       EX_pc;
    logic              EX_is_branch;
    logic              EX_is_jal;
    logic              EX_taken;
    logic [31:0]       EX_target;
    logic              EX_pred_taken;
    logic [31:0]       EX_pred_target;
    logic [BHT_IW-1:0] EX_bht_idx;
    logic              EX_prediction_incorrect;

    // Core side: drives PCs and resolutions, consumes predictions
    modport master (
        output IF_pc, EX_feedback_valid, EX_pc, EX_is_branch, EX_is_jal, EX_taken,
               EX_target, EX_pred_taken, EX_pred_target, EX_bht_idx,
        input  pred_taken, pred_target, pred_bht_idx, EX_prediction_incorrect
    );

    // Predictor side
    modport slave (
        input  IF_pc, EX_feedback_valid, EX_pc, EX_is_branch, EX_is_jal, EX_taken,
               EX_target, EX_pred_taken, EX_pred_target, EX_bht_idx,
        output pred_taken, pred_target, pred_bht_idx, EX_prediction_incorrect
    );
endinterface

// File: rtl/branch_predictor.sv
// IF-stage predictor: 2-bit saturating BHT + direct-mapped BTB, trained from EX; GSHARE_EN adds global history.
// Latency: zero-cycle lookup and mispredict flag; updates visible the cycle after the training edge (no bypass).
// Backpressure: none; feedback is accepted every cycle EX_feedback_valid is high.
module branch_predictor #(
    parameter int         BHT_ENTRIES = 64,
    parameter int         BTB_ENTRIES = 16,
    parameter logic [1:0] BHT_INIT    = 2'b01
) (
    input  logic               clk,
    input  logic               rst_n,
    branch_predictor_if.slave  bp
);
    localparam int BHT_IW = $clog2(BHT_ENTRIES);
    localparam int BTB_IW = $clog2(BTB_ENTRIES);
    localparam int TAG_W  = 30 - BTB_IW;

    logic [1:0]             bht_q [BHT_ENTRIES];
    logic [1:0]             bht_d;
    logic [BTB_ENTRIES-1:0] btb_valid_q;
    logic [BTB_ENTRIES-1:0] btb_jal_q;
    logic [TAG_W-1:0]       btb_tag_q [BTB_ENTRIES];
    logic [31:0]            btb_target_q [BTB_ENTRIES];

    // ---------------- lookup ----------------
    logic [BTB_IW-1:0] if_btb_idx;
    logic [TAG_W-1:0]  if_tag;
    logic [BHT_IW-1:0] if_bht_idx;
    logic              if_hit;

    assign if_btb_idx = bp.IF_pc[BTB_IW+1:2];
    assign if_tag     = bp.IF_pc[31:BTB_IW+2];

`ifdef GSHARE_EN
    logic [BHT_IW-1:0] ghr_q;
    assign if_bht_idx = bp.IF_pc[BHT_IW+1:2] ^ ghr_q;
`else
    assign if_bht_idx = bp.IF_pc[BHT_IW+1:2];
`endif

    assign if_hit          = btb_valid_q[if_btb_idx] && (btb_tag_q[if_btb_idx] == if_tag);
    assign bp.pred_taken   = if_hit && (btb_jal_q[if_btb_idx] || bht_q[if_bht_idx][1]);
    assign bp.pred_target  = bp.pred_taken ? btb_target_q[if_btb_idx] : 32'd0;
    assign bp.pred_bht_idx = if_bht_idx;

    // ---------------- mispredict ----------------
    assign bp.EX_prediction_incorrect = bp.EX_feedback_valid
                                     && (bp.EX_is_branch || bp.EX_is_jal)
                                     && ((bp.EX_taken != bp.EX_pred_taken)
                                         || (bp.EX_taken && (bp.EX_target != bp.EX_pred_target)));

    // ---------------- training controls ----------------
    // A branch+jal combination is treated as a jal, so only pure branches train the BHT.
    logic              br_upd;
    logic              btb_wr;
    logic [BTB_IW-1:0] ex_btb_idx;
    logic [TAG_W-1:0]  ex_tag;

    assign br_upd     = bp.EX_feedback_valid && bp.EX_is_branch && !bp.EX_is_jal;
    assign btb_wr     = bp.EX_feedback_valid && (bp.EX_is_branch || bp.EX_is_jal) && bp.EX_taken;
    assign ex_btb_idx = bp.EX_pc[BTB_IW+1:2];
    assign ex_tag     = bp.EX_pc[31:BTB_IW+2];

    // Saturating next value for the counter being trained
    always_comb begin
        bht_d = bht_q[bp.EX_bht_idx];
        if (bp.EX_taken) begin
            if (bht_d != 2'b11) bht_d = bht_d + 2'd1;
        end else begin
            if (bht_d != 2'b00) bht_d = bht_d - 2'd1;
        end
    end

    // Direction counters: reset to BHT_INIT, train on resolved conditional branches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= BHT_INIT;
        end else if (br_upd) begin
            bht_q[bp.EX_bht_idx] <= bht_d;
        end
    end

    // BTB valid bits: cleared on reset, set whenever a taken transfer is recorded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btb_valid_q <= '0;
        end else if (btb_wr) begin
            btb_valid_q[ex_btb_idx] <= 1'b1;
        end
    end

    // BTB payload: guarded by the valid bit, so no reset is needed
    always_ff @(posedge clk) begin
        if (btb_wr) begin
            btb_tag_q[ex_btb_idx]    <= ex_tag;
            btb_target_q[ex_btb_idx] <= bp.EX_target;
            btb_jal_q[ex_btb_idx]    <= bp.EX_is_jal;
        end
    end

`ifdef GSHARE_EN
    // Non-speculative global history: shifts only on resolved conditional branches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_q <= '0;
        end else if (br_upd) begin
            ghr_q <= {ghr_q[BHT_IW-2:0], bp.EX_taken};
        end
    end
`endif

    // PC byte-offset bits carry no information for word-aligned fetch
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bp.IF_pc[1:0], bp.EX_pc[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor (64-entry BHT, 16-entry BTB).
// Lookups and feedback push expectations into scoreboard queues; they are popped when outputs are sampled.
// A reference model of the tables drives the randomized phase.
module tb_branch_predictor;
    logic clk;
    logic rst_n;

    branch_predictor_if #(.BHT_IW(6)) bp ();

    branch_predictor #(.BHT_ENTRIES(64), .BTB_ENTRIES(16), .BHT_INIT(2'b01)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [1:0]  m_bht [64];
    logic [15:0] m_val;
    logic [15:0] m_jal;
    logic [25:0] m_tag [16];
    logic [31:0] m_tgt [16];
    logic [5:0]  m_ghr;

    function automatic void m_reset();
        for (int i = 0; i < 64; i++) m_bht[i] = 2'b01;
        m_val = '0;
        m_jal = '0;
        m_ghr = '0;
    endfunction

    function automatic void m_predict(input logic [31:0] pc, output logic t,
                                      output logic [31:0] tg);
        logic [3:0] bi;
        logic [5:0] hi;
        logic       hit;
        bi  = pc[5:2];
        hi  = pc[7:2] ^ m_ghr;
        hit = m_val[bi] && (m_tag[bi] == pc[31:6]);
        t   = hit && (m_jal[bi] || m_bht[hi][1]);
        tg  = t ? m_tgt[bi] : 32'd0;
    endfunction

    function automatic void m_train(input logic vld, input logic [31:0] pc, input logic br,
                                    input logic jal, input logic tk, input logic [31:0] tgt);
        logic [3:0] bi;
        logic [5:0] hi;
        bi = pc[5:2];
        hi = pc[7:2] ^ m_ghr;
        if (!vld) return;
        if (br && !jal) begin
            if (tk && m_bht[hi] != 2'b11) m_bht[hi] = m_bht[hi] + 2'd1;
            if (!tk && m_bht[hi] != 2'b00) m_bht[hi] = m_bht[hi] - 2'd1;
`ifdef GSHARE_EN
            m_ghr = {m_ghr[4:0], tk};
`endif
        end
        if ((br || jal) && tk) begin
            m_val[bi] = 1'b1;
            m_jal[bi] = jal;
            m_tag[bi] = pc[31:6];
            m_tgt[bi] = tgt;
        end
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        taken;
        logic [31:0] target;
        logic [5:0]  idx;
    } exp_t;

    exp_t  look_q[$];
    logic  inc_q[$];

    task automatic lookup(input string tag, input logic [31:0] pc, input logic et,
                          input logic [31:0] etg);
        exp_t e;
        @(negedge clk);
        bp.IF_pc = pc;
        e.taken  = et;
        e.target = etg;
        e.idx    = pc[7:2] ^ m_ghr;
        look_q.push_back(e);
        #2;
        e = look_q.pop_front();
        check({tag, "_taken"},  32'(bp.pred_taken),   32'(e.taken));
        check({tag, "_target"}, bp.pred_target,       e.target);
        check({tag, "_idx"},    32'(bp.pred_bht_idx), 32'(e.idx));
    endtask

    task automatic drive_fb(input logic vld, input logic [31:0] pc, input logic br,
                            input logic jal, input logic tk, input logic [31:0] tgt,
                            input logic ptk, input logic [31:0] ptgt);
        bp.EX_feedback_valid = vld;
        bp.EX_pc             = pc;
        bp.EX_is_branch      = br;
        bp.EX_is_jal         = jal;
        bp.EX_taken          = tk;
        bp.EX_target         = tgt;
        bp.EX_pred_taken     = ptk;
        bp.EX_pred_target    = ptgt;
        bp.EX_bht_idx        = pc[7:2] ^ m_ghr;
    endtask

    task automatic fb(input string tag, input logic vld, input logic [31:0] pc, input logic br,
                      input logic jal, input logic tk, input logic [31:0] tgt, input logic ptk,
                      input logic [31:0] ptgt, input logic exp_inc);
        @(negedge clk);
        drive_fb(vld, pc, br, jal, tk, tgt, ptk, ptgt);
        inc_q.push_back(exp_inc);
        #2;
        check(tag, 32'(bp.EX_prediction_incorrect), 32'(inc_q.pop_front()));
        m_train(vld, pc, br, jal, tk, tgt);
        @(posedge clk);
        #1;
        bp.EX_feedback_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic        t;
        logic [31:0] tg;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        br, jal, tk, vld, inc;
        int          kind;

        rst_n = 1'b0;
        bp.IF_pc = 32'h100;
        drive_fb(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        m_reset();
        #1;
        check("rst_taken",  32'(bp.pred_taken), 32'd0);
        check("rst_target", bp.pred_target,     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        lookup("post_rst", 32'h100, 1'b0, 32'h0);

`ifndef GSHARE_EN
        // Branch at 0x100 taken to 0x80, predicted not-taken
        fb("t2_inc", 1, 32'h100, 1, 0, 1, 32'h80, 0, 32'h0, 1);
        lookup("t2", 32'h100, 1'b1, 32'h80);
        // Saturate at 11, then two not-taken
        for (int i = 0; i < 4; i++) fb("t3_tk", 1, 32'h100, 1, 0, 1, 32'h80, 1, 32'h80, 0);
        fb("t3_nt1", 1, 32'h100, 1, 0, 0, 32'h0, 1, 32'h80, 1);
        lookup("t3_nt1", 32'h100, 1'b1, 32'h80);
        fb("t3_nt2", 1, 32'h100, 1, 0, 0, 32'h0, 1, 32'h80, 1);
        lookup("t3_nt2", 32'h100, 1'b0, 32'h0);

        // JAL 0x200 -> 0x400 shares BTB slot 0 with 0x100
        fb("t4_jal", 1, 32'h200, 0, 1, 1, 32'h400, 0, 32'h0, 1);
        lookup("t4_jal", 32'h200, 1'b1, 32'h400);
        lookup("t4_alias", 32'h240, 1'b0, 32'h0);
        lookup("t4_evict", 32'h100, 1'b0, 32'h0);

        // Correct direction, wrong target
        fb("t5_retrain", 1, 32'h100, 1, 0, 1, 32'h80, 0, 32'h0, 1);
        lookup("t5_retrain", 32'h100, 1'b1, 32'h80);
        fb("t5_wrongtgt", 1, 32'h100, 1, 0, 1, 32'h84, 1, 32'h80, 1);
        lookup("t5_newtgt", 32'h100, 1'b1, 32'h84);
        fb("t5_correct", 1, 32'h100, 1, 0, 1, 32'h84, 1, 32'h84, 0);
        // Invalid feedback must neither flag nor train
        fb("t5_inv_jal", 0, 32'h100, 0, 1, 1, 32'h500, 0, 32'h0, 0);
        fb("t5_inv_nt1", 0, 32'h100, 1, 0, 0, 32'h0, 1, 32'h84, 0);
        fb("t5_inv_nt2", 0, 32'h100, 1, 0, 0, 32'h0, 1, 32'h84, 0);
        fb("t5_inv_nt3", 0, 32'h100, 1, 0, 0, 32'h0, 1, 32'h84, 0);
        lookup("t5_inv", 32'h100, 1'b1, 32'h84);

        // Counter floor at 00: N,N,N then T leaves 01 (not taken)
        for (int i = 0; i < 3; i++) fb("sat0_nt", 1, 32'h104, 1, 0, 0, 32'h0, 0, 32'h0, 0);
        fb("sat0_tk", 1, 32'h104, 1, 0, 1, 32'h40, 0, 32'h0, 1);
        lookup("sat0_a", 32'h104, 1'b0, 32'h0);
        fb("sat0_tk2", 1, 32'h104, 1, 0, 1, 32'h40, 0, 32'h0, 1);
        lookup("sat0_b", 32'h104, 1'b1, 32'h40);

        // Branch+jal together behaves as jal and leaves the BHT alone
        fb("ill_fb", 1, 32'h108, 1, 1, 1, 32'h700, 0, 32'h0, 1);
        lookup("ill_jal", 32'h108, 1'b1, 32'h700);
        fb("ill_br_tk", 1, 32'h108, 1, 0, 1, 32'h700, 1, 32'h700, 0);
        fb("ill_br_nt", 1, 32'h108, 1, 0, 0, 32'h0, 1, 32'h700, 1);
        lookup("ill_bht", 32'h108, 1'b0, 32'h0);

        // Same-cycle lookup and update: lookup sees the old entry
        @(negedge clk);
        drive_fb(1, 32'h30C, 0, 1, 1, 32'h600, 0, 32'h0);
        bp.IF_pc = 32'h30C;
        #2;
        check("same_cyc_taken",  32'(bp.pred_taken), 32'd0);
        check("same_cyc_target", bp.pred_target,     32'd0);
        check("same_cyc_inc",    32'(bp.EX_prediction_incorrect), 32'd1);
        m_train(1, 32'h30C, 0, 1, 1, 32'h600);
        @(posedge clk);
        #1;
        bp.EX_feedback_valid = 1'b0;
        lookup("same_cyc_next", 32'h30C, 1'b1, 32'h600);

        // Reset asserted in the middle of an update
        @(negedge clk);
        drive_fb(1, 32'h100, 1, 0, 1, 32'h88, 1, 32'h84);
        bp.IF_pc = 32'h100;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_taken",  32'(bp.pred_taken), 32'd0);
        check("rst_mid_target", bp.pred_target,     32'd0);
        check("rst_mid_inc",    32'(bp.EX_prediction_incorrect), 32'd1);
        @(posedge clk);
        #1;
        bp.EX_feedback_valid = 1'b0;
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        lookup("rst_mid_btb", 32'h100, 1'b0, 32'h0);
        fb("rst_mid_tk", 1, 32'h100, 1, 0, 1, 32'h80, 0, 32'h0, 1);
        lookup("rst_mid_tk", 32'h100, 1'b1, 32'h80);
        fb("rst_mid_nt", 1, 32'h100, 1, 0, 0, 32'h0, 1, 32'h80, 1);
        lookup("rst_mid_bht", 32'h100, 1'b0, 32'h0);
`else
        // Global history after T,N,T is ...101; jal does not shift it
        fb("gs_t1", 1, 32'h400, 1, 0, 1, 32'h80, 0, 32'h0, 1);
        fb("gs_n",  1, 32'h400, 1, 0, 0, 32'h0,  0, 32'h0, 0);
        fb("gs_t2", 1, 32'h400, 1, 0, 1, 32'h80, 0, 32'h0, 1);
        @(negedge clk);
        bp.IF_pc = 32'h410;
        #2;
        check("gs_idx", 32'(bp.pred_bht_idx), 32'h01);
        fb("gs_jal", 1, 32'h500, 0, 1, 1, 32'h900, 0, 32'h0, 1);
        @(negedge clk);
        bp.IF_pc = 32'h410;
        #2;
        check("gs_idx_jal", 32'(bp.pred_bht_idx), 32'h01);
`endif

        // Randomized traffic against the reference model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            pc = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            m_predict(pc, t, tg);
            lookup("rnd_lk", pc, t, tg);
            kind = $urandom_range(0, 5);
            br   = (kind <= 2) || (kind == 5);
            jal  = (kind == 3) || (kind == 5);
            tk   = jal ? 1'b1 : 1'($urandom_range(0, 1));
            tgt  = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            if (t && $urandom_range(0, 1) == 1) tgt = tg;
            vld  = ($urandom_range(0, 7) != 0);
            inc  = vld && (br || jal) && ((tk != t) || (tk && (tgt != tg)));
            fb("rnd_fb", vld, pc, br, jal, tk, tgt, t, tg, inc);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
